// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM and HI/LO buses, extracts load data
// from the data SRAM and drives the WB bus and the ID forwarding path.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70,
    parameter int HILO_WD      = 66
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [HILO_WD-1:0]      hilo_ex_to_mem,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id,
    output logic [HILO_WD-1:0]      hilo_mem_to_wb,
    output logic                    mem_is_load
);

    logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
    logic [HILO_WD-1:0]      hilo_q, hilo_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [31:0]             rdata_hold_q, rdata_hold_d;

    logic [3:0]  readen_s;
    logic [31:0] pc_s;
    logic        sel_rf_res_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] ex_result_s;
    logic [31:0] rd_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_data_s;
    logic [31:0] rf_wdata_s;
    logic        unused_bits_s;

    assign readen_s     = bus_q[79:76];
    assign pc_s         = bus_q[75:44];
    assign sel_rf_res_s = bus_q[38];
    assign rf_we_s      = bus_q[37];
    assign rf_waddr_s   = bus_q[36:32];
    assign ex_result_s  = bus_q[31:0];
    // Store controls are consumed by EX when it drives the SRAM; nothing to do here.
    assign unused_bits_s = ^{bus_q[43:39], stall[5], stall[2:0]};

    // Stage register next state: bubble, capture or hold.
    always_comb begin
        bus_d  = bus_q;
        hilo_d = hilo_q;
        if (stall[3] && !stall[4]) begin
            bus_d  = '0;
            hilo_d = '0;
        end else if (!stall[3]) begin
            bus_d  = ex_to_mem_bus;
            hilo_d = hilo_ex_to_mem;
        end else begin
            bus_d  = bus_q;
            hilo_d = hilo_q;
        end
    end

    // Read-data hold: latch the SRAM word on the first stalled MEM cycle.
    always_comb begin
        hold_valid_d = hold_valid_q;
        rdata_hold_d = rdata_hold_q;
        if (stall[4] && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end else if (!stall[4]) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q        <= '0;
            hilo_q       <= '0;
            hold_valid_q <= 1'b0;
            rdata_hold_q <= 32'd0;
        end else begin
            bus_q        <= bus_d;
            hilo_q       <= hilo_d;
            hold_valid_q <= hold_valid_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign rd_s   = hold_valid_q ? rdata_hold_q : data_sram_rdata;
    assign half_s = ex_result_s[1] ? rd_s[31:16] : rd_s[15:0];

    // Byte lane select and load extension.
    always_comb begin
        byte_s      = 8'd0;
        load_data_s = 32'd0;
        case (ex_result_s[1:0])
            2'd0:    byte_s = rd_s[7:0];
            2'd1:    byte_s = rd_s[15:8];
            2'd2:    byte_s = rd_s[23:16];
            2'd3:    byte_s = rd_s[31:24];
            default: byte_s = 8'd0;
        endcase
        case (readen_s)
            4'b1111: load_data_s = rd_s;
            4'b0001: load_data_s = {{24{byte_s[7]}}, byte_s};
            4'b0010: load_data_s = {24'd0, byte_s};
            4'b0011: load_data_s = {{16{half_s[15]}}, half_s};
            4'b0100: load_data_s = {16'd0, half_s};
            default: load_data_s = 32'd0;
        endcase
    end

    assign rf_wdata_s     = sel_rf_res_s ? load_data_s : ex_result_s;
    assign mem_to_wb_bus  = {pc_s, rf_we_s, rf_waddr_s, rf_wdata_s};
    assign mem_to_id      = {rf_we_s, rf_waddr_s, rf_wdata_s};
    assign hilo_mem_to_wb = hilo_q;
    assign mem_is_load    = |readen_s;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expectations are queued when stimulus is driven
// and popped when the stage output is sampled.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic [5:0]  stall;
    logic [79:0] ex_bus;
    logic [65:0] hilo_in;
    logic [31:0] rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id;
    logic [65:0] hilo_out;
    logic        mem_is_load;

    typedef struct {
        string       tag;
        logic [69:0] wb;
        logic [37:0] id;
        logic [65:0] hilo;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    localparam logic [65:0] HILO_AB = {1'b1, 1'b1, 32'h0000_000A, 32'h0000_000B};
    localparam logic [65:0] HILO_CD = {1'b0, 1'b0, 32'h0000_000C, 32'h0000_000D};
    localparam logic [65:0] HILO_EF = {1'b1, 1'b0, 32'h0000_000E, 32'h0000_000F};
    localparam logic [5:0]  ST_NONE = 6'b000000;
    localparam logic [5:0]  ST_EXMEM = 6'b011000;
    localparam logic [5:0]  ST_EX   = 6'b001000;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .hilo_ex_to_mem  (hilo_in),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id       (mem_to_id),
        .hilo_mem_to_wb  (hilo_out),
        .mem_is_load     (mem_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] mk(input logic [3:0] readen, input logic [31:0] pc,
                                       input logic [3:0] wen, input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        logic ram_en;
        ram_en = (|wen) | (|readen);
        return {readen, pc, ram_en, wen, sel, we, wa, res};
    endfunction

    function automatic void push_exp(input string tag, input logic [31:0] pc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd,
                                     input logic [65:0] h, input logic ld);
        exp_t e;
        e.tag  = tag;
        e.wb   = {pc, we, wa, wd};
        e.id   = {we, wa, wd};
        e.hilo = h;
        e.ld   = ld;
        sb.push_back(e);
    endfunction

    task automatic check_out();
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard: queue empty at check");
        end else begin
            e = sb.pop_front();
            assert ({mem_to_wb_bus, mem_to_id, hilo_out, mem_is_load} === {e.wb, e.id, e.hilo, e.ld})
            else begin
                miscompares++;
                $error("FAIL %s: got wb=%h id=%h hilo=%h ld=%b, expected wb=%h id=%h hilo=%h ld=%b",
                       e.tag, mem_to_wb_bus, mem_to_id, hilo_out, mem_is_load,
                       e.wb, e.id, e.hilo, e.ld);
            end
        end
    endtask

    task automatic step(input logic [79:0] b, input logic [65:0] h, input logic [5:0] s);
        @(negedge clk);
        ex_bus  = b;
        hilo_in = h;
        stall   = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn  = 1'b0;
        stall   = ST_NONE;
        ex_bus  = 80'd0;
        hilo_in = 66'd0;
        rdata   = 32'd0;

        #12;
        push_exp("reset", 32'd0, 1'b0, 5'd0, 32'd0, 66'd0, 1'b0);
        check_out();
        @(negedge clk);
        resetn = 1'b1;

        step(mk(4'b0001, 32'h100, 4'd0, 1'b1, 1'b1, 5'd3, 32'h13), 66'd0, ST_NONE);
        rdata = 32'h8012_3456; #1;
        push_exp("lb", 32'h100, 1'b1, 5'd3, 32'hFFFF_FF80, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0010, 32'h104, 4'd0, 1'b1, 1'b1, 5'd3, 32'h13), 66'd0, ST_NONE);
        #1;
        push_exp("lbu", 32'h104, 1'b1, 5'd3, 32'h0000_0080, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0011, 32'h108, 4'd0, 1'b1, 1'b1, 5'd4, 32'h22), 66'd0, ST_NONE);
        rdata = 32'hBEEF_7FFF; #1;
        push_exp("lh", 32'h108, 1'b1, 5'd4, 32'hFFFF_BEEF, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0100, 32'h10C, 4'd0, 1'b1, 1'b1, 5'd4, 32'h20), 66'd0, ST_NONE);
        #1;
        push_exp("lhu", 32'h10C, 1'b1, 5'd4, 32'h0000_7FFF, 66'd0, 1'b1);
        check_out();

        step(mk(4'b1111, 32'h110, 4'd0, 1'b1, 1'b1, 5'd4, 32'h23), 66'd0, ST_NONE);
        #1;
        push_exp("lw", 32'h110, 1'b1, 5'd4, 32'hBEEF_7FFF, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0011, 32'h114, 4'd0, 1'b1, 1'b1, 5'd6, 32'h21), 66'd0, ST_NONE);
        #1;
        push_exp("lh_odd", 32'h114, 1'b1, 5'd6, 32'h0000_7FFF, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0001, 32'h118, 4'd0, 1'b1, 1'b1, 5'd6, 32'h20), 66'd0, ST_NONE);
        #1;
        push_exp("lb_lane0", 32'h118, 1'b1, 5'd6, 32'hFFFF_FFFF, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0101, 32'h11C, 4'd0, 1'b1, 1'b1, 5'd6, 32'h20), 66'd0, ST_NONE);
        #1;
        push_exp("bad_code", 32'h11C, 1'b1, 5'd6, 32'd0, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0000, 32'h120, 4'd0, 1'b0, 1'b1, 5'd7, 32'h0000_DEAD), 66'd0, ST_NONE);
        #1;
        push_exp("alu", 32'h120, 1'b1, 5'd7, 32'h0000_DEAD, 66'd0, 1'b0);
        check_out();

        step(mk(4'b0000, 32'h124, 4'b1111, 1'b0, 1'b0, 5'd0, 32'h40), 66'd0, ST_NONE);
        #1;
        push_exp("store", 32'h124, 1'b0, 5'd0, 32'h40, 66'd0, 1'b0);
        check_out();

        step(mk(4'b0000, 32'h128, 4'd0, 1'b0, 1'b1, 5'd0, 32'h5), 66'd0, ST_NONE);
        #1;
        push_exp("waddr0", 32'h128, 1'b1, 5'd0, 32'h5, 66'd0, 1'b0);
        check_out();

        // Multi-cycle MEM stall: data sampled in the first stalled cycle must stick.
        step(mk(4'b1111, 32'h200, 4'd0, 1'b1, 1'b1, 5'd8, 32'h0), 66'd0, ST_NONE);
        rdata = 32'h11;
        stall = ST_EXMEM; #1;
        push_exp("hold_c0", 32'h200, 1'b1, 5'd8, 32'h11, 66'd0, 1'b1);
        check_out();
        @(posedge clk); #1;
        rdata = 32'h22; #1;
        push_exp("hold_c1", 32'h200, 1'b1, 5'd8, 32'h11, 66'd0, 1'b1);
        check_out();
        @(posedge clk); #1;
        rdata = 32'h33; #1;
        push_exp("hold_c2", 32'h200, 1'b1, 5'd8, 32'h11, 66'd0, 1'b1);
        check_out();

        step(mk(4'b1111, 32'h204, 4'd0, 1'b1, 1'b1, 5'd8, 32'h4), 66'd0, ST_NONE);
        rdata = 32'h44; #1;
        push_exp("release", 32'h204, 1'b1, 5'd8, 32'h44, 66'd0, 1'b1);
        check_out();

        // Reset while stalled with held data.
        stall = ST_EXMEM;
        @(posedge clk); #1;
        rdata = 32'h55; #1;
        push_exp("midstall", 32'h204, 1'b1, 5'd8, 32'h44, 66'd0, 1'b1);
        check_out();
        resetn = 1'b0; #1;
        push_exp("rst_mid", 32'd0, 1'b0, 5'd0, 32'd0, 66'd0, 1'b0);
        check_out();
        @(negedge clk);
        resetn = 1'b1;
        stall  = ST_NONE;

        step(mk(4'b1111, 32'h300, 4'd0, 1'b1, 1'b1, 5'd9, 32'h0), 66'd0, ST_NONE);
        rdata = 32'h66; #1;
        push_exp("post_rst", 32'h300, 1'b1, 5'd9, 32'h66, 66'd0, 1'b1);
        check_out();

        step(mk(4'b0000, 32'h400, 4'd0, 1'b0, 1'b1, 5'd5, 32'h7), HILO_AB, ST_EX);
        #1;
        push_exp("bubble", 32'd0, 1'b0, 5'd0, 32'd0, 66'd0, 1'b0);
        check_out();

        step(mk(4'b0000, 32'h500, 4'd0, 1'b0, 1'b1, 5'd9, 32'h99), HILO_AB, ST_NONE);
        #1;
        push_exp("hilo_cap", 32'h500, 1'b1, 5'd9, 32'h99, HILO_AB, 1'b0);
        check_out();

        step(mk(4'b0000, 32'h504, 4'd0, 1'b0, 1'b1, 5'd11, 32'h77), HILO_CD, ST_EXMEM);
        #1;
        push_exp("hold1", 32'h500, 1'b1, 5'd9, 32'h99, HILO_AB, 1'b0);
        check_out();

        step(mk(4'b0001, 32'h508, 4'd0, 1'b1, 1'b0, 5'd12, 32'h78), HILO_EF, ST_EXMEM);
        #1;
        push_exp("hold2", 32'h500, 1'b1, 5'd9, 32'h99, HILO_AB, 1'b0);
        check_out();

        step(mk(4'b0000, 32'h50C, 4'd0, 1'b0, 1'b1, 5'd10, 32'h88), HILO_AB, ST_NONE);
        #1;
        push_exp("release_hilo", 32'h50C, 1'b1, 5'd10, 32'h88, HILO_AB, 1'b0);
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
